// File: rtl/alm_arb_pkg.sv
// Shared types and the round-robin pick function used by the multiplier arbiter.
package alm_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int PTR_W   = $clog2(MAX_REQ);

    typedef struct packed {
        logic signed [7:0] a;
        logic signed [7:0] b;
    } alm_op_t;

    typedef struct packed {
        logic [PTR_W-1:0]   id;
        logic signed [15:0] z;
    } alm_rsp_t;

    // Unused requester slots are tied low by the caller, so wrapping modulo
    // MAX_REQ finds the same first requester as wrapping modulo the real count.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input logic [PTR_W-1:0]   ptr);
        logic [MAX_REQ-1:0] grant;
        logic [PTR_W-1:0]   idx;
        logic               found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = ptr + PTR_W'(i);
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/dr_alm_8bit_signed.sv
// Signed 8x8 approximate logarithmic (Mitchell) multiplier; each operand keeps
// TRUNC_WIDTH significant bits (leading one included) before the log-domain add.
module dr_alm_8bit_signed #(
    parameter int TRUNC_WIDTH = 6
) (
    input  logic signed [7:0]  i_a,
    input  logic signed [7:0]  i_b,
    output logic signed [15:0] o_z
);

    localparam logic [6:0] FRAC_MASK = 7'(7'h7F << (8 - TRUNC_WIDTH));

    // Returns {characteristic, truncated 7-bit mantissa fraction}.
    function automatic logic [9:0] to_log(input logic [7:0] m);
        logic [2:0] k;
        logic [6:0] f;
        k = '0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) k = 3'(i);
        end
        f = 7'(m << (3'd7 - k));
        return {k, f & FRAC_MASK};
    endfunction

    logic [7:0]  mag_a, mag_b;
    logic [9:0]  log_a, log_b;
    logic [7:0]  frac_sum;
    logic [3:0]  char_sum, shift;
    logic [8:0]  mant;
    logic [23:0] wide;
    logic [15:0] mag;

    always_comb begin
        mag_a    = i_a[7] ? 8'(-i_a) : 8'(i_a);
        mag_b    = i_b[7] ? 8'(-i_b) : 8'(i_b);
        log_a    = to_log(mag_a);
        log_b    = to_log(mag_b);
        frac_sum = {1'b0, log_a[6:0]} + {1'b0, log_b[6:0]};
        char_sum = {1'b0, log_a[9:7]} + {1'b0, log_b[9:7]};
        // A fraction sum of one or more carries into the characteristic.
        if (frac_sum[7]) begin
            mant  = {1'b0, frac_sum};
            shift = char_sum + 4'd1;
        end else begin
            mant  = {2'b01, frac_sum[6:0]};
            shift = char_sum;
        end
        wide = 24'(mant) << shift;
        mag  = 16'(wide >> 7);
        if (mag_a == 8'd0 || mag_b == 8'd0) begin
            o_z = '0;
        end else if (i_a[7] ^ i_b[7]) begin
            o_z = -$signed(mag);
        end else begin
            o_z = $signed(mag);
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
module rr_arbiter
    import alm_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_valid,
    input  logic         i_en,
    output logic [N-1:0] o_grant
);

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [MAX_REQ-1:0] valid_ext;
    logic [MAX_REQ-1:0] pick;
    logic               unused_pick;

    // NOTE: every variable written here gets a default before any branch, so no latch is inferred.
    always_comb begin
        valid_ext          = '0;
        valid_ext[N-1:0]   = i_valid;
        pick               = rr_pick(valid_ext, rr_ptr_q);
        o_grant            = i_en ? pick[N-1:0] : '0;
        rr_ptr_d           = rr_ptr_q;
        for (int i = 0; i < N; i++) begin
            if (o_grant[i]) begin
                rr_ptr_d = (i == N - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    assign unused_pick = ^pick;

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/alm_mult_arbiter.sv
// Shares one approximate multiplier among NUM_REQ requesters through a
// round-robin grant and a two-stage (operand, result) pipeline.
module alm_mult_arbiter
    import alm_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TRUNC_WIDTH = 6,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    input  logic [NUM_REQ-1:0][7:0] i_req_a,
    input  logic [NUM_REQ-1:0][7:0] i_req_b,
    output logic [NUM_REQ-1:0]      o_req_ready,
    output logic                    o_rsp_valid,
    output logic [ID_W-1:0]         o_rsp_id,
    output logic signed [15:0]      o_rsp_z,
    input  logic                    i_rsp_ready,
    output logic [31:0]             o_op_count,
    output logic                    o_busy
);

    alm_op_t            s1_q, s1_d;
    logic [ID_W-1:0]    id1_q, id1_d;
    logic               v1_q, v1_d;
    logic signed [15:0] z2_q;
    logic [ID_W-1:0]    id2_q;
    logic               v2_q;
    logic [31:0]        count_q, count_d;
    logic               adv, grant_en;
    logic [NUM_REQ-1:0] grant;
    logic signed [15:0] mult_z;

    assign adv      = !v2_q || i_rsp_ready;
    // Gating with reset keeps every grant low for the whole reset window.
    assign grant_en = adv && i_rst_n;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_req_valid),
        .i_en    (grant_en),
        .o_grant (grant)
    );

    dr_alm_8bit_signed #(.TRUNC_WIDTH(TRUNC_WIDTH)) u_mult (
        .i_a (s1_q.a),
        .i_b (s1_q.b),
        .o_z (mult_z)
    );

    always_comb begin
        s1_d  = '0;
        id1_d = '0;
        v1_d  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                s1_d.a = i_req_a[i];
                s1_d.b = i_req_b[i];
                id1_d  = ID_W'(i);
                v1_d   = 1'b1;
            end
        end
        count_d = count_q;
        if (v2_q && i_rsp_ready && count_q != '1) begin
            count_d = count_q + 32'd1;
        end
    end

    // NOTE: data registers are reset too, so o_rsp_z/o_rsp_id read zero straight out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_q    <= '0;
            id1_q   <= '0;
            v1_q    <= 1'b0;
            z2_q    <= '0;
            id2_q   <= '0;
            v2_q    <= 1'b0;
            count_q <= '0;
        end else begin
            if (adv) begin
                s1_q  <= s1_d;
                id1_q <= id1_d;
                v1_q  <= v1_d;
                z2_q  <= mult_z;
                id2_q <= id1_q;
                v2_q  <= v1_q;
            end
            count_q <= count_d;
        end
    end

    assign o_req_ready = grant;
    assign o_rsp_valid = v2_q;
    assign o_rsp_id    = id2_q;
    assign o_rsp_z     = z2_q;
    assign o_op_count  = count_q;
    assign o_busy      = v1_q | v2_q;

endmodule
